dmem_access_ctrl: RTL and testbench

- Initiator-side sequencer that drives the data memory block (store unit, block RAM, load unit) on behalf of the pipeline MEM stage.
- The data memory only supports naturally aligned accesses. This block accepts arbitrary-alignment loads and stores through a valid/ready request port.
- It splits misaligned accesses into aligned data-memory transactions, honours the RAM read latency, and merges and extends load data.
- It returns a single-cycle response pulse to the pipeline.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_access_ctrl_load_merge_ext.sv | 32 +++
 rtl/dmem_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: funct3 codes,
// FSM state encoding and the access-size helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD_A = 3'd1,
        LD_B = 3'd2,
        ST_B = 3'd3,
        RESP = 3'd4,
        ERR  = 3'd5
    } state_t;

    // Access size in bytes (1, 2, 4 or 8) from the low funct3 bits.
    function automatic logic [3:0] size_of(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_merge_ext.sv
// Combinational merge of one or two aligned doublewords into a load result:
// shift the byte window down by the offset, then sign/zero-extend per funct3.
module load_merge_ext
    import dmem_pkg::*;
(
    input  logic [63:0] i_lo,
    input  logic [63:0] i_hi,
    input  logic [2:0]  i_offset,
    input  logic [2:0]  i_func3,
    output logic [63:0] o_ext
);

    logic [5:0]  w_shamt;
    logic [63:0] w_raw;

    assign w_shamt = {i_offset, 3'b000};
    assign w_raw   = 64'({i_hi, i_lo} >> w_shamt);

    always_comb begin
        o_ext = w_raw;
        case (i_func3[1:0])
            2'd0:    o_ext = i_func3[2] ? {56'd0, w_raw[7:0]}
                                        : {{56{w_raw[7]}}, w_raw[7:0]};
            2'd1:    o_ext = i_func3[2] ? {48'd0, w_raw[15:0]}
                                        : {{48{w_raw[15]}}, w_raw[15:0]};
            2'd2:    o_ext = i_func3[2] ? {32'd0, w_raw[31:0]}
                                        : {{32{w_raw[31]}}, w_raw[31:0]};
            default: o_ext = w_raw;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer for the naturally-aligned data memory: accepts any
// alignment, splits misaligned accesses, and returns a one-cycle response.
//
// state | meaning
// IDLE  | ready for a request
// LD_A  | first (or only) load access, 1+RD_LAT cycles
// LD_B  | upper doubleword of a crossing load, 1+RD_LAT cycles
// ST_B  | store: one full store, or one byte store per cycle
// RESP  | resp_valid pulse for a completed access
// ERR   | resp_valid + resp_err pulse, no memory access made
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int RD_LAT      = 1,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        dmem_we,
    output logic        dmem_re,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_data,
    output logic [2:0]  dmem_func3,
    input  logic [63:0] dmem_rdata
);

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_off;
    logic [2:0]  r_func3;
    logic        r_aligned;
    logic        r_cross;
    logic [63:0] r_lo;
    logic [63:0] r_wdata;

    logic [3:0]  w_size;
    logic        w_f3_ok;
    logic        w_mis;
    logic        w_cross;
    logic [63:0] w_merge_lo;
    logic [63:0] w_merged;

    assign w_size   = size_of(req_func3);
    assign w_f3_ok  = req_we ? ~req_func3[2] : (req_func3 != 3'b111);
    assign w_mis    = (req_addr[3:0] & (w_size - 4'd1)) != 4'd0;
    assign w_cross  = ({1'b0, req_addr[2:0]} + w_size) > 4'd8;

    assign req_ready = (r_state == IDLE);

    // In LD_B the lower half comes from the LD_A sample; otherwise hi is a don't-care.
    assign w_merge_lo = (r_state == LD_B) ? r_lo : dmem_rdata;

    load_merge_ext u_merge (
        .i_lo     (w_merge_lo),
        .i_hi     (dmem_rdata),
        .i_offset (r_off),
        .i_func3  (r_func3),
        .o_ext    (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_off      <= 3'd0;
            r_func3    <= 3'd0;
            r_aligned  <= 1'b0;
            r_cross    <= 1'b0;
            r_lo       <= 64'd0;
            r_wdata    <= 64'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_re    <= 1'b0;
            dmem_addr  <= 64'd0;
            dmem_data  <= 64'd0;
            dmem_func3 <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    if (req_valid) begin
                        r_off     <= req_addr[2:0];
                        r_func3   <= req_func3;
                        r_aligned <= ~w_mis;
                        r_cross   <= w_cross;
                        r_wdata   <= req_wdata >> 8;
                        if (!w_f3_ok || (w_mis && !MISALIGN_EN)) begin
                            r_state    <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 64'd0;
                        end else if (req_we) begin
                            r_state   <= ST_B;
                            dmem_we   <= 1'b1;
                            dmem_addr <= req_addr;
                            if (w_mis) begin
                                dmem_func3 <= F3_B;
                                dmem_data  <= {56'd0, req_wdata[7:0]};
                                r_cnt      <= 3'(w_size - 4'd1);
                            end else begin
                                dmem_func3 <= req_func3;
                                dmem_data  <= req_wdata;
                                r_cnt      <= 3'd0;
                            end
                        end else begin
                            r_state <= LD_A;
                            dmem_re <= 1'b1;
                            r_cnt   <= LAT_INIT;
                            if (w_mis) begin
                                dmem_addr  <= {req_addr[63:3], 3'b000};
                                dmem_func3 <= F3_D;
                            end else begin
                                dmem_addr  <= req_addr;
                                dmem_func3 <= req_func3;
                            end
                        end
                    end
                end

                LD_A: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else if (r_aligned) begin
                        resp_rdata <= dmem_rdata;
                        resp_valid <= 1'b1;
                        dmem_re    <= 1'b0;
                        r_state    <= RESP;
                    end else if (r_cross) begin
                        r_lo      <= dmem_rdata;
                        dmem_addr <= dmem_addr + 64'd8;
                        r_cnt     <= LAT_INIT;
                        r_state   <= LD_B;
                    end else begin
                        resp_rdata <= w_merged;
                        resp_valid <= 1'b1;
                        dmem_re    <= 1'b0;
                        r_state    <= RESP;
                    end
                end

                LD_B: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        resp_rdata <= w_merged;
                        resp_valid <= 1'b1;
                        dmem_re    <= 1'b0;
                        r_state    <= RESP;
                    end
                end

                ST_B: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt     <= r_cnt - 3'd1;
                        dmem_addr <= dmem_addr + 64'd1;
                        dmem_data <= {56'd0, r_wdata[7:0]};
                        r_wdata   <= r_wdata >> 8;
                    end else begin
                        dmem_we    <= 1'b0;
                        resp_rdata <= 64'd0;
                        resp_valid <= 1'b1;
                        r_state    <= RESP;
                    end
                end

                RESP, ERR: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    r_state    <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 32-byte data memory model
// (RD_LAT=1) and a second instance built with misaligned splitting disabled.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_func3;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic        dmem_we, dmem_re;
    logic [63:0] dmem_addr, dmem_data, dmem_rdata;
    logic [2:0]  dmem_func3;

    logic        n_req_valid, n_req_ready, n_req_we;
    logic [63:0] n_req_addr, n_req_wdata;
    logic [2:0]  n_req_func3;
    logic        n_resp_valid, n_resp_err;
    logic [63:0] n_resp_rdata;
    logic        n_dmem_we, n_dmem_re;
    logic [63:0] n_dmem_addr, n_dmem_data;
    logic [2:0]  n_dmem_func3;
    logic [63:0] n_dmem_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    dmem_access_ctrl #(.RD_LAT(1), .MISALIGN_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_addr(dmem_addr),
        .dmem_data(dmem_data), .dmem_func3(dmem_func3), .dmem_rdata(dmem_rdata)
    );

    dmem_access_ctrl #(.RD_LAT(1), .MISALIGN_EN(1'b0)) u_dut_nm (
        .clk(clk), .rst(rst),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
        .req_addr(n_req_addr), .req_wdata(n_req_wdata), .req_func3(n_req_func3),
        .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err),
        .dmem_we(n_dmem_we), .dmem_re(n_dmem_re), .dmem_addr(n_dmem_addr),
        .dmem_data(n_dmem_data), .dmem_func3(n_dmem_func3), .dmem_rdata(n_dmem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---- data memory model: byte array, registered dword read, formatting load unit
    logic [7:0]  mem [0:31];
    logic [63:0] r_word;
    logic        pl_en;
    logic [4:0]  pl_base;
    logic [63:0] pl_word;

    always @(posedge clk) begin
        if (pl_en)
            for (int i = 0; i < 8; i++) mem[{pl_base[4:3], 3'(i)}] <= pl_word[8*i +: 8];
        if (dmem_we)
            for (int i = 0; i < (1 << dmem_func3[1:0]); i++)
                mem[5'(dmem_addr[4:0] + 5'(i))] <= dmem_data[8*i +: 8];
        if (dmem_re)
            for (int i = 0; i < 8; i++) r_word[8*i +: 8] <= mem[{dmem_addr[4:3], 3'(i)}];
    end

    function automatic logic [63:0] fmt(input logic [63:0] w, input logic [2:0] off,
                                        input logic [2:0] f3);
        logic [63:0] s;
        s = w >> (8 * off);
        case (f3)
            3'b000:  return {{56{s[7]}}, s[7:0]};
            3'b001:  return {{48{s[15]}}, s[15:0]};
            3'b010:  return {{32{s[31]}}, s[31:0]};
            3'b100:  return {56'd0, s[7:0]};
            3'b101:  return {48'd0, s[15:0]};
            3'b110:  return {32'd0, s[31:0]};
            default: return s;
        endcase
    endfunction

    assign dmem_rdata   = fmt(r_word, dmem_addr[2:0], dmem_func3);
    assign n_dmem_rdata = 64'd0;

    int   resp_pulses = 0;
    logic n_re_seen   = 1'b0;
    logic n_we_seen   = 1'b0;
    always @(posedge clk) begin
        if (resp_valid) resp_pulses++;
        if (n_dmem_re) n_re_seen <= 1'b1;
        if (n_dmem_we) n_we_seen <= 1'b1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] base, input logic [63:0] w);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_base = base;
        pl_word = w;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    logic [63:0] re_q[$];
    logic [63:0] st_addr_q[$];
    logic [63:0] st_data_q[$];

    // Issue one request, then watch every cycle until resp_valid (bounded).
    // lat is the cycle index after the handshake edge (T+lat), -1 on timeout.
    task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [2:0] f3, input bit hold, output int lat,
                          output logic [63:0] rdata, output logic err,
                          output int re_cyc, output int we_cyc);
        lat = -1; rdata = 'x; err = 'x; re_cyc = 0; we_cyc = 0;
        re_q.delete(); st_addr_q.delete(); st_data_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_func3 = f3;
        @(posedge clk);
        #1;
        if (hold) begin
            req_we = 1'b0; req_addr = 64'h18; req_func3 = 3'b011;
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dmem_re) begin
                re_cyc++;
                if (re_q.size() == 0 || re_q[$] != dmem_addr) re_q.push_back(dmem_addr);
            end
            if (dmem_we) begin
                we_cyc++;
                st_addr_q.push_back(dmem_addr);
                st_data_q.push_back(dmem_data);
            end
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    int          lat, re_cyc, we_cyc, pulses0;
    logic [63:0] rd;
    logic        er;

    initial begin
        rst = 1'b1; pl_en = 1'b0; pl_base = '0; pl_word = '0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_func3 = '0;
        n_req_valid = 1'b0; n_req_we = 1'b0; n_req_addr = '0; n_req_wdata = '0; n_req_func3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready",  64'(req_ready),  64'd1);
        check_val("rst_rvalid", 64'(resp_valid), 64'd0);
        check_val("rst_err",    64'(resp_err),   64'd0);
        check_val("rst_we_re",  64'({dmem_we, dmem_re}), 64'd0);
        check_val("rst_addr",   dmem_addr,  64'd0);
        check_val("rst_data",   dmem_data,  64'd0);
        check_val("rst_f3",     64'(dmem_func3), 64'd0);
        check_val("rst_rdata",  resp_rdata, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // aligned LD
        preload(5'h10, 64'h8877665544332211);
        do_req(1'b0, 64'h10, 64'd0, 3'b011, 1'b0, lat, rd, er, re_cyc, we_cyc);
        check_val("ld_lat",   64'(lat),    64'd3);
        check_val("ld_rdata", rd,          64'h8877665544332211);
        check_val("ld_re_cyc", 64'(re_cyc), 64'd2);
        check_val("ld_addr",  re_q[0],     64'h10);
        check_val("ld_err",   64'(er),     64'd0);
        @(negedge clk);
        check_val("ld_pulse1", 64'(resp_valid), 64'd0);
        check_val("ld_ready",  64'(req_ready),  64'd1);
        check_val("ld_hold_rdata", resp_rdata,  64'h8877665544332211);

        // crossing LW at 0x06
        preload(5'h00, 64'h8877665544332211);
        preload(5'h08, 64'h000000000000FFFF);
        do_req(1'b0, 64'h06, 64'd0, 3'b010, 1'b0, lat, rd, er, re_cyc, we_cyc);
        check_val("lw_x_lat",   64'(lat), 64'd5);
        check_val("lw_x_rdata", rd,       64'hFFFFFFFFFFFF8877);
        check_val("lw_x_nacc",  64'(re_q.size()), 64'd2);
        check_val("lw_x_addr0", re_q[0],  64'h00);
        check_val("lw_x_addr1", re_q[1],  64'h08);

        // non-crossing misaligned LHU at 0x03
        do_req(1'b0, 64'h03, 64'd0, 3'b101, 1'b0, lat, rd, er, re_cyc, we_cyc);
        check_val("lhu_lat",   64'(lat), 64'd3);
        check_val("lhu_rdata", rd,       64'h0000000000005544);
        check_val("lhu_addr",  re_q[0],  64'h00);

        // misaligned SW at 0x0D, req_valid held high while busy
        do_req(1'b1, 64'h0D, 64'hDEADBEEF, 3'b010, 1'b1, lat, rd, er, re_cyc, we_cyc);
        check_val("sw_lat",    64'(lat),    64'd5);
        check_val("sw_we_cyc", 64'(we_cyc), 64'd4);
        check_val("sw_no_re",  64'(re_cyc), 64'd0);
        check_val("sw_a0", st_addr_q[0], 64'h0D);
        check_val("sw_a3", st_addr_q[3], 64'h10);
        check_val("sw_d0", st_data_q[0], 64'hEF);
        check_val("sw_d1", st_data_q[1], 64'hBE);
        check_val("sw_d2", st_data_q[2], 64'hAD);
        check_val("sw_d3", st_data_q[3], 64'hDE);
        check_val("sw_rdata", rd, 64'd0);
        do_req(1'b0, 64'h0D, 64'd0, 3'b010, 1'b0, lat, rd, er, re_cyc, we_cyc);
        check_val("lw_rb_lat",   64'(lat), 64'd5);
        check_val("lw_rb_rdata", rd,       64'hFFFFFFFFDEADBEEF);

        // aligned SD then LD back
        do_req(1'b1, 64'h18, 64'h0123456789ABCDEF, 3'b011, 1'b0, lat, rd, er, re_cyc, we_cyc);
        check_val("sd_lat",    64'(lat),    64'd2);
        check_val("sd_we_cyc", 64'(we_cyc), 64'd1);
        check_val("sd_data",   st_data_q[0], 64'h0123456789ABCDEF);
        do_req(1'b0, 64'h18, 64'd0, 3'b011, 1'b0, lat, rd, er, re_cyc, we_cyc);
        check_val("sd_rb", rd, 64'h0123456789ABCDEF);

        // bad funct3
        do_req(1'b1, 64'h20, 64'h55, 3'b100, 1'b0, lat, rd, er, re_cyc, we_cyc);
        check_val("bad_st_lat", 64'(lat),    64'd1);
        check_val("bad_st_err", 64'(er),     64'd1);
        check_val("bad_st_we",  64'(we_cyc), 64'd0);
        do_req(1'b0, 64'h00, 64'd0, 3'b111, 1'b0, lat, rd, er, re_cyc, we_cyc);
        check_val("bad_ld_lat", 64'(lat),    64'd1);
        check_val("bad_ld_err", 64'(er),     64'd1);
        check_val("bad_ld_re",  64'(re_cyc), 64'd0);
        @(negedge clk);
        check_val("err_pulse1", 64'({resp_valid, resp_err}), 64'd0);

        // MISALIGN_EN=0 instance, LH at 0x01
        @(negedge clk);
        n_req_valid = 1'b1; n_req_we = 1'b0; n_req_addr = 64'h01; n_req_func3 = 3'b001;
        @(posedge clk);
        #1 n_req_valid = 1'b0;
        @(negedge clk);
        check_val("nm_rvalid", 64'(n_resp_valid), 64'd1);
        check_val("nm_err",    64'(n_resp_err),   64'd1);
        @(negedge clk);
        check_val("nm_pulse1", 64'(n_resp_valid), 64'd0);
        check_val("nm_ready",  64'(n_req_ready),  64'd1);
        check_val("nm_no_acc", 64'({n_re_seen, n_we_seen}), 64'd0);

        // reset during a misaligned SD at 0x01, before its second byte
        preload(5'h00, 64'h1111111111111111);
        preload(5'h08, 64'h2222222222222222);
        pulses0 = resp_pulses;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h01;
        req_wdata = 64'hA7A6A5A4A3A2A1A0; req_func3 = 3'b011;
        @(posedge clk);
        @(negedge clk);
        check_val("rsd_busy",  64'(req_ready), 64'd0);
        check_val("rsd_b0_we", 64'(dmem_we),   64'd1);
        check_val("rsd_b0_a",  dmem_addr,      64'h01);
        rst = 1'b1;
        @(posedge clk);
        #1 begin rst = 1'b0; req_valid = 1'b0; end
        @(negedge clk);
        check_val("rsd_ready", 64'(req_ready),  64'd1);
        check_val("rsd_we",    64'(dmem_we),    64'd0);
        check_val("rsd_rv",    64'(resp_valid), 64'd0);
        repeat (10) @(negedge clk);
        check_val("rsd_no_resp", 64'(resp_pulses - pulses0), 64'd0);
        check_val("rsd_byte0", 64'(mem[1]), 64'hA0);
        check_val("rsd_byte1", 64'(mem[2]), 64'h11);
        check_val("rsd_byte7", 64'(mem[8]), 64'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
